// File: rtl/alu_pkg.sv
// Shared definitions for alu_seq_unit: base op codes, RV-M funct3 codes,
// FSM state encoding and the base-op decode helper.
package alu_pkg;

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b1000;
    localparam logic [3:0] OpSll  = 4'b0001;
    localparam logic [3:0] OpSlt  = 4'b0010;
    localparam logic [3:0] OpSltu = 4'b0011;
    localparam logic [3:0] OpXor  = 4'b0100;
    localparam logic [3:0] OpSrl  = 4'b0101;
    localparam logic [3:0] OpSra  = 4'b1101;
    localparam logic [3:0] OpOr   = 4'b0110;
    localparam logic [3:0] OpAnd  = 4'b0111;

    localparam logic [2:0] F3Mul    = 3'b000;
    localparam logic [2:0] F3Mulh   = 3'b001;
    localparam logic [2:0] F3Mulhsu = 3'b010;
    localparam logic [2:0] F3Mulhu  = 3'b011;
    localparam logic [2:0] F3Div    = 3'b100;
    localparam logic [2:0] F3Divu   = 3'b101;
    localparam logic [2:0] F3Rem    = 3'b110;
    localparam logic [2:0] F3Remu   = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } alu_state_e;

    typedef enum logic [3:0] {
        FnAdd, FnSub, FnSll, FnSlt, FnSltu, FnXor, FnSrl, FnSra, FnOr, FnAnd, FnIllegal
    } base_fn_e;

    function automatic base_fn_e base_decode(input logic [3:0] op);
        base_fn_e fn;
        case (op)
            OpAdd:   fn = FnAdd;
            OpSub:   fn = FnSub;
            OpSll:   fn = FnSll;
            OpSlt:   fn = FnSlt;
            OpSltu:  fn = FnSltu;
            OpXor:   fn = FnXor;
            OpSrl:   fn = FnSrl;
            OpSra:   fn = FnSra;
            OpOr:    fn = FnOr;
            OpAnd:   fn = FnAnd;
            default: fn = FnIllegal;
        endcase
        return fn;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative RV-M engine: shift-add multiply / restoring divide on operand magnitudes,
// one iteration per cycle for XLEN cycles, sign fix-up applied on the final iteration.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CntW = $clog2(XLEN);

    logic            run_q, run_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            is_div_q, is_div_d, sel_hi_q, sel_hi_d;
    logic            res_neg_q, res_neg_d, rem_neg_q, rem_neg_d;
    logic [XLEN-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d;

    logic            is_div, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum, div_sh, div_diff;
    logic [XLEN-1:0] hi_n, lo_n, quo, rem;
    logic [2*XLEN-1:0] prod, prod_fix;

    always_comb begin
        is_div   = op[2];
        a_signed = is_div ? ~op[0] : (op == F3Mulh || op == F3Mulhsu);
        b_signed = is_div ? ~op[0] : (op == F3Mulh);
        a_neg    = a_signed & operand1[XLEN-1];
        b_neg    = b_signed & operand2[XLEN-1];
        a_mag    = a_neg ? -operand1 : operand1;
        b_mag    = b_neg ? -operand2 : operand2;
    end

    // mul: hi:lo holds partial product:multiplier; div: hi:lo holds remainder:dividend/quotient
    always_comb begin
        mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? m_q : {XLEN{1'b0}})};
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_diff = div_sh - {1'b0, m_q};
        if (is_div_q) begin
            if (!div_diff[XLEN]) begin
                hi_n = div_diff[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_n = div_sh[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod     = {hi_n, lo_n};
        prod_fix = res_neg_q ? -prod : prod;
        quo      = res_neg_q ? -lo_n : lo_n;
        rem      = rem_neg_q ? -hi_n : hi_n;
        if (is_div_q) begin
            result = sel_hi_q ? rem : quo;
        end else begin
            result = sel_hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
        end
        done = run_q & (cnt_q == '0);
    end

    always_comb begin
        run_d     = run_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        sel_hi_d  = sel_hi_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (kill) begin
            run_d = 1'b0;
        end else if (start) begin
            run_d     = 1'b1;
            cnt_d     = CntW'(XLEN - 1);
            is_div_d  = is_div;
            sel_hi_d  = is_div ? op[1] : (op != F3Mul);
            res_neg_d = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            m_d       = is_div ? b_mag : a_mag;
            hi_d      = '0;
            lo_d      = is_div ? a_mag : b_mag;
        end else if (run_q) begin
            hi_d  = hi_n;
            lo_d  = lo_n;
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q     <= 1'b0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            sel_hi_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            run_q     <= run_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            sel_hi_q  <= sel_hi_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked EX-stage ALU: base RV32I ops in one cycle, RV-M ops on an iterative engine
// when ALU_MULDIV_EN is defined (otherwise RV-M codes report illegal).
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [XLEN-1:0] in_operand1,
    input  logic [XLEN-1:0] in_operand2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal,
    output logic            busy
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] base_res;
    logic            base_ill;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = in_operand2[SHAMT_W-1:0];

    always_comb begin
        base_res = '0;
        base_ill = 1'b0;
        unique case (base_decode(in_op[3:0]))
            FnAdd:   base_res = in_operand1 + in_operand2;
            FnSub:   base_res = in_operand1 - in_operand2;
            FnSll:   base_res = in_operand1 << shamt;
            FnSlt:   base_res = {{(XLEN-1){1'b0}}, $signed(in_operand1) < $signed(in_operand2)};
            FnSltu:  base_res = {{(XLEN-1){1'b0}}, in_operand1 < in_operand2};
            FnXor:   base_res = in_operand1 ^ in_operand2;
            FnSrl:   base_res = in_operand1 >> shamt;
            FnSra:   base_res = $unsigned($signed(in_operand1) >>> shamt);
            FnOr:    base_res = in_operand1 | in_operand2;
            FnAnd:   base_res = in_operand1 & in_operand2;
            default: base_ill = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic            md_start, md_done;
    logic [XLEN-1:0] md_result;
    logic            div_zero, div_ovf, md_special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] int_min;

    assign int_min = {1'b1, {(XLEN-1){1'b0}}};

    // Divide-by-zero and signed overflow bypass the engine entirely
    always_comb begin
        div_zero    = in_op[2] && (in_operand2 == '0);
        div_ovf     = in_op[2] && !in_op[0] && (in_operand1 == int_min) && (&in_operand2);
        md_special  = div_zero || div_ovf;
        if (div_zero) begin
            special_res = in_op[1] ? in_operand1 : {XLEN{1'b1}};
        end else begin
            special_res = in_op[1] ? {XLEN{1'b0}} : int_min;
        end
    end

    alu_muldiv_iter #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .kill     (kill),
        .start    (md_start),
        .op       (in_op[2:0]),
        .operand1 (in_operand1),
        .operand2 (in_operand2),
        .done     (md_done),
        .result   (md_result)
    );
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
`ifdef ALU_MULDIV_EN
        md_start  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid && !kill) begin
                    state_d = StDone;
                    if (!in_op[4]) begin
                        result_d  = base_res;
                        illegal_d = base_ill;
                    end else begin
`ifdef ALU_MULDIV_EN
                        illegal_d = 1'b0;
                        if (md_special) begin
                            result_d = special_res;
                        end else begin
                            state_d  = StBusy;
                            md_start = 1'b1;
                        end
`else
                        result_d  = '0;
                        illegal_d = 1'b1;
`endif
                    end
                end
            end
            StBusy: begin
`ifdef ALU_MULDIV_EN
                if (md_done) begin
                    state_d   = StDone;
                    result_d  = md_result;
                    illegal_d = 1'b0;
                end
`else
                state_d = StIdle;
`endif
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (kill) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StDone);
    assign out_result  = result_q;
    assign out_illegal = illegal_q;
`ifdef ALU_MULDIV_EN
    assign busy = (state_q == StBusy);
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// Randomised self-checking bench for alu_seq_unit (XLEN=32) against an arithmetic reference model;
// expectations follow ALU_MULDIV_EN so either build can be checked.
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kill = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0;
    logic [31:0] in_operand1 = '0;
    logic [31:0] in_operand2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_illegal;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;
    logic busy_seen = 1'b0;

    localparam logic [31:0] MinInt = 32'h8000_0000;

    always #5 clk = ~clk;

    always @(posedge clk) if (busy === 1'b1) busy_seen <= 1'b1;

    alu_seq_unit #(
        .XLEN(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .kill        (kill),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_operand1 (in_operand1),
        .in_operand2 (in_operand2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    function automatic void ref_model(input logic [4:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] r,
                                      output logic ill, output int lat);
        longint sa, sb;
        logic [63:0] ua, ub, p;
        int sh;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        sh  = int'(b % 32);
        r   = '0;
        ill = 1'b0;
        lat = 1;
        if (!op[4]) begin
            case (op[3:0])
                4'b0000: r = a + b;
                4'b1000: r = a - b;
                4'b0001: begin p = ua << sh; r = p[31:0]; end
                4'b0010: r = (sa < sb) ? 32'd1 : 32'd0;
                4'b0011: r = (ua < ub) ? 32'd1 : 32'd0;
                4'b0100: r = a ^ b;
                4'b0101: r = a / (32'd1 << sh);
                4'b1101: r = 32'(sa >>> sh);
                4'b0110: r = a | b;
                4'b0111: r = a & b;
                default: ill = 1'b1;
            endcase
        end else begin
`ifdef ALU_MULDIV_EN
            lat = 33;
            case (op[2:0])
                3'd0: begin p = ua * ub; r = p[31:0]; end
                3'd1: begin p = sa * sb; r = p[63:32]; end
                3'd2: begin p = sa * longint'(ua) * 0 + sa * longint'(ub); r = p[63:32]; end
                3'd3: begin p = ua * ub; r = p[63:32]; end
                default: begin
                    if (b == 0) begin
                        lat = 1;
                        r = op[1] ? a : 32'hFFFF_FFFF;
                    end else if (!op[0] && a == MinInt && b == 32'hFFFF_FFFF) begin
                        lat = 1;
                        r = op[1] ? 32'h0 : MinInt;
                    end else if (!op[0]) begin
                        r = op[1] ? 32'(sa % sb) : 32'(sa / sb);
                    end else begin
                        r = op[1] ? a % b : a / b;
                    end
                end
            endcase
`else
            ill = 1'b1;
`endif
        end
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MinInt;
            3: return $urandom_range(0, 9);
            4: return -$urandom_range(1, 9);
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input string name);
        logic [31:0] er;
        logic ei;
        int el, lat;
        ref_model(op, a, b, er, ei, el);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
        end
        in_valid = 1'b1;
        in_op = op;
        in_operand1 = a;
        in_operand2 = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op = 5'($urandom);
        in_operand1 = $urandom;
        in_operand2 = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_cmp++;
        if (lat != el) begin
            n_fail++;
            $display("FAIL %s latency op=%b a=%h b=%h: got %0d want %0d", name, op, a, b, lat, el);
        end
        n_cmp++;
        if (out_result !== er) begin
            n_fail++;
            $display("FAIL %s result op=%b a=%h b=%h: got %h want %h", name, op, a, b,
                     out_result, er);
        end
        n_cmp++;
        if (out_illegal !== ei) begin
            n_fail++;
            $display("FAIL %s illegal op=%b: got %b want %b", name, op, out_illegal, ei);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_result !== er || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s stall cycle %0d: valid=%b result=%h ready=%b want 1/%h/0",
                         name, i, out_valid, out_result, in_ready, er);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s release: valid=%b ready=%b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_illegal !== 1'b0 ||
            busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: valid=%b result=%h illegal=%b busy=%b ready=%b want 0/0/0/0/1",
                     name, out_valid, out_result, out_illegal, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(5'b01101, 32'h8000_0000, 32'h0000_0024, 0, "sra");
        run_op(5'b00010, 32'hFFFF_FFFF, 32'h1, 0, "slt");
        run_op(5'b00011, 32'hFFFF_FFFF, 32'h1, 0, "sltu");
        run_op(5'b01000, 32'h0, 32'h1, 0, "sub");
        run_op(5'b01001, 32'h1234, 32'h5678, 0, "illegal_1001");
        run_op(5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulh");
        run_op(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");
        run_op(5'b10100, -32'd7, 32'd2, 0, "div");
        run_op(5'b10110, -32'd7, 32'd2, 0, "rem");
        run_op(5'b10100, 32'd1234, 32'd0, 0, "div_by_zero");
        run_op(5'b10100, MinInt, 32'hFFFF_FFFF, 0, "div_ovf");
        run_op(5'b10000, 32'd3, 32'd4, 0, "mul");
    endtask

    task automatic test_stall();
        run_op(5'b00000, 32'h1111_0000, 32'h0000_2222, 10, "stall_add");
    endtask

    task automatic test_kill();
        int seen;
        // kill while a result waits in DONE
        @(negedge clk);
        in_valid = 1'b1;
        in_op = 5'b00110;
        in_operand1 = 32'hF0;
        in_operand2 = 32'h0F;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL kill_done: valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        // kill together with in_valid must not accept
        @(negedge clk);
        in_valid = 1'b1;
        kill = 1'b1;
        in_op = 5'b00000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        kill = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_accept: valid=%b ready=%b busy=%b want 0/1/0",
                     out_valid, in_ready, busy);
        end
`ifdef ALU_MULDIV_EN
        @(negedge clk);
        in_valid = 1'b1;
        in_op = 5'b10101;
        in_operand1 = 32'd1000;
        in_operand2 = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL kill_busy_pre: busy=%b want 1", busy);
        end
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_busy: valid=%b ready=%b busy=%b want 0/1/0",
                     out_valid, in_ready, busy);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL kill_busy_after: out_valid cycles got %0d want 0", seen);
        end
`endif
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        in_valid = 1'b1;
`ifdef ALU_MULDIV_EN
        in_op = 5'b10011;
`else
        in_op = 5'b00000;
`endif
        in_operand1 = 32'hDEAD_BEEF;
        in_operand2 = 32'h1357_9BDF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [4:0] op;
        for (int i = 0; i < 60; i++) begin
            op = 5'($urandom);
            run_op(op, rand_operand(), rand_operand(), 0, "random");
        end
    endtask

    task automatic test_busy_flag();
        logic exp_seen;
`ifdef ALU_MULDIV_EN
        exp_seen = 1'b1;
`else
        exp_seen = 1'b0;
`endif
        n_cmp++;
        if (busy_seen !== exp_seen) begin
            n_fail++;
            $display("FAIL busy_seen: got %b want %b", busy_seen, exp_seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_kill();
        test_rst_mid();
        test_random();
        test_busy_flag();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
